// File: rtl/imem_loader.sv
// Instruction-memory loader: packs WISC-SP13 fields into 16-bit words, buffers them in a
// small FIFO and writes them to consecutive addresses through an acknowledged write port.
module imem_loader #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_opcode,
  input  logic [1:0]        in_func,
  input  logic [2:0]        in_rs,
  input  logic [2:0]        in_rt,
  input  logic [2:0]        in_rd,
  input  logic [10:0]       in_imm,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_data,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              imm_err,
  output logic [ADDR_W-1:0] words_written
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);
  localparam logic [4:0] OP_HALT = 5'b00000;

  typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} state_e;

  state_e            state_q;
  logic              busy_q, done_q, imm_err_q;
  logic [ADDR_W-1:0] addr_q, words_q;

  logic [15:0]      fifo_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;

  logic        fifo_full, fifo_empty, push, pop;
  logic [15:0] enc_word;
  logic        imm_bad;

  // Encoder and immediate range check
  always_comb begin
    enc_word = {in_opcode, 11'b0};
    imm_bad  = 1'b0;
    casez (in_opcode)
      5'b00100, 5'b00110: enc_word = {in_opcode, in_imm};
      5'b00101, 5'b00111, 5'b011??, 5'b11000: begin
        enc_word = {in_opcode, in_rs, in_imm[7:0]};
        imm_bad  = !((&in_imm[10:7]) || !(|in_imm[10:7]));
      end
      5'b10010: begin
        enc_word = {in_opcode, in_rs, in_imm[7:0]};
        imm_bad  = |in_imm[10:8];
      end
      5'b01000, 5'b01001, 5'b10000, 5'b10001, 5'b10011: begin
        enc_word = {in_opcode, in_rs, in_rd, in_imm[4:0]};
        imm_bad  = !((&in_imm[10:4]) || !(|in_imm[10:4]));
      end
      5'b01010, 5'b01011, 5'b101??: begin
        enc_word = {in_opcode, in_rs, in_rd, in_imm[4:0]};
        imm_bad  = |in_imm[10:5];
      end
      5'b11001:                     enc_word = {in_opcode, in_rs, 3'b000, in_rd, 2'b00};
      5'b11010, 5'b11011, 5'b111??: enc_word = {in_opcode, in_rs, in_rt, in_rd, in_func};
      5'b00010:                     enc_word = {in_opcode, in_rs, 8'b0};
      default:                      enc_word = {in_opcode, 11'b0};
    endcase
  end

  assign fifo_full  = (count_q == FULL_COUNT);
  assign fifo_empty = (count_q == '0);
  assign in_ready   = (state_q == StLoad) && !fifo_full;
  assign push       = in_valid && in_ready;
  assign mem_wr_en  = busy_q && !fifo_empty;
  assign pop        = mem_wr_en && mem_ack;

  // Storage needs no reset; mem_data is gated so it reads 0 when idle
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= enc_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      imm_err_q <= 1'b0;
      addr_q    <= '0;
      words_q   <= '0;
    end else begin
      if (pop) begin
        addr_q  <= addr_q + ADDR_W'(2);
        words_q <= words_q + ADDR_W'(1);
      end
      if (push && imm_bad) imm_err_q <= 1'b1;
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q   <= StLoad;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            imm_err_q <= 1'b0;
            addr_q    <= {base_addr[ADDR_W-1:1], 1'b0};
            words_q   <= '0;
          end
        end
        StLoad: begin
          if (push && in_opcode == OP_HALT) state_q <= StDrain;
        end
        StDrain: begin
          // Empty FIFO means the last write has already been acknowledged
          if (fifo_empty) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_addr      = addr_q;
  assign mem_data      = mem_wr_en ? fifo_q[rd_ptr_q] : 16'h0000;
  assign busy          = busy_q;
  assign done          = done_q;
  assign imm_err       = imm_err_q;
  assign words_written = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected {addr, word} pairs are queued on each accepted
// transfer and compared against every acknowledged memory write.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_ready, mem_wr_en, mem_ack;
  logic        busy, done, imm_err;
  logic [15:0] base_addr, mem_addr, mem_data, words_written;
  logic [4:0]  in_opcode;
  logic [1:0]  in_func;
  logic [2:0]  in_rs, in_rt, in_rd;
  logic [10:0] in_imm;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] sb[$];
  logic [15:0] exp_addr;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(4), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_func(in_func),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack),
    .busy(busy), .done(done), .imm_err(imm_err), .words_written(words_written)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Write monitor: every acknowledged write must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && mem_wr_en && mem_ack) begin
      if (sb.size() == 0) begin
        check("sb_underflow", sb.size(), 1);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        check("wr_addr", {16'h0, mem_addr}, {16'h0, e[31:16]});
        check("wr_data", {16'h0, mem_data}, {16'h0, e[15:0]});
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge
  task automatic start_session(input logic [15:0] base);
    base_addr = base;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    exp_addr  = base & 16'hFFFE;
  endtask

  task automatic send(input logic [4:0] op, input logic [1:0] func, input logic [2:0] rs,
                      input logic [2:0] rt, input logic [2:0] rd, input logic [10:0] imm,
                      input logic [15:0] exp_word);
    in_opcode = op; in_func = func; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm;
    in_valid  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (!in_ready) begin
      check("send_ready", {31'h0, in_ready}, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sb.push_back({exp_addr, exp_word});
    exp_addr = exp_addr + 16'd2;
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done(input logic [15:0] exp_words, input logic exp_err);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check("done", {31'h0, done}, 1);
    @(posedge clk); #1;
    check("busy_after_done", {31'h0, busy}, 0);
    check("words_written", {16'h0, words_written}, {16'h0, exp_words});
    check("imm_err", {31'h0, imm_err}, {31'h0, exp_err});
    check("sb_empty", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; mem_ack = 1'b1;
    in_opcode = '0; in_func = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0;
    exp_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'h0, in_ready}, 0);
    check("rst_wr_en", {31'h0, mem_wr_en}, 0);
    check("rst_busy", {31'h0, busy}, 0);
    check("rst_done", {31'h0, done}, 0);
    check("rst_imm_err", {31'h0, imm_err}, 0);
    check("rst_words", {16'h0, words_written}, 0);
    check("rst_addr", {16'h0, mem_addr}, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Basic session: ADDI then HALT
    start_session(16'h0100);
    send(5'b01000, 2'd0, 3'd1, 3'd0, 3'd2, 11'h7FD, 16'h415D);
    send(5'b00000, 2'd0, 3'd0, 3'd0, 3'd0, 11'h000, 16'h0000);
    wait_done(16'd2, 1'b0);

    // Format coverage
    start_session(16'h0200);
    check("done_cleared", {31'h0, done}, 0);
    send(5'b11011, 2'd0, 3'd3, 3'd4, 3'd5, 11'h000, 16'hDB94);
    send(5'b11001, 2'd3, 3'd1, 3'd7, 3'd2, 11'h000, 16'hC908);
    send(5'b00100, 2'd0, 3'd0, 3'd0, 3'd0, 11'h7FE, 16'h27FE);
    send(5'b11000, 2'd0, 3'd6, 3'd0, 3'd0, 11'h07F, 16'hC67F);
    send(5'b00000, 2'd0, 3'd0, 3'd0, 3'd0, 11'h000, 16'h0000);
    wait_done(16'd5, 1'b0);

    // Immediate range errors
    start_session(16'h0300);
    send(5'b10101, 2'd0, 3'd2, 3'd0, 3'd3, 11'h020, 16'hAA60);
    check("imm_err_slli", {31'h0, imm_err}, 1);
    send(5'b01100, 2'd0, 3'd4, 3'd0, 3'd0, 11'h77F, 16'h647F);
    send(5'b00000, 2'd0, 3'd0, 3'd0, 3'd0, 11'h000, 16'h0000);
    wait_done(16'd3, 1'b1);

    // Back-pressure: memory stalls, FIFO fills
    mem_ack = 1'b0;
    start_session(16'h0400);
    check("imm_err_cleared", {31'h0, imm_err}, 0);
    send(5'b00001, 2'd0, 3'd0, 3'd0, 3'd0, 11'h000, 16'h0800);
    send(5'b00010, 2'd0, 3'd5, 3'd0, 3'd0, 11'h000, 16'h1500);
    send(5'b11011, 2'd1, 3'd1, 3'd2, 3'd3, 11'h000, 16'hD94D);
    send(5'b10010, 2'd0, 3'd7, 3'd0, 3'd0, 11'h0FF, 16'h97FF);
    in_opcode = 5'b01011; in_rs = 3'd1; in_rd = 3'd2; in_imm = 11'h01F; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_in_ready", {31'h0, in_ready}, 0);
      check("stall_wr_en", {31'h0, mem_wr_en}, 1);
      check("stall_addr", {16'h0, mem_addr}, 32'h0400);
      check("stall_data", {16'h0, mem_data}, 32'h0800);
    end
    check("stall_words", {16'h0, words_written}, 0);
    @(posedge clk); #1;
    mem_ack = 1'b1;
    send(5'b01011, 2'd0, 3'd1, 3'd0, 3'd2, 11'h01F, 16'h595F);
    check("imm_err_unsigned_ok", {31'h0, imm_err}, 0);
    send(5'b00110, 2'd0, 3'd0, 3'd0, 3'd0, 11'h3FF, 16'h33FF);
    send(5'b00000, 2'd0, 3'd0, 3'd0, 3'd0, 11'h000, 16'h0000);
    wait_done(16'd7, 1'b0);

    // Address wrap; bit 0 of base ignored
    start_session(16'hFFFF);
    send(5'b01000, 2'd0, 3'd0, 3'd0, 3'd0, 11'h000, 16'h4000);
    send(5'b00000, 2'd0, 3'd0, 3'd0, 3'd0, 11'h000, 16'h0000);
    wait_done(16'd2, 1'b0);
    check("wrap_addr_after", {16'h0, mem_addr}, 32'h0002);

    // Reset mid-session
    mem_ack = 1'b0;
    start_session(16'h0500);
    send(5'b00001, 2'd0, 3'd0, 3'd0, 3'd0, 11'h000, 16'h0800);
    send(5'b00001, 2'd0, 3'd0, 3'd0, 3'd0, 11'h000, 16'h0800);
    send(5'b00001, 2'd0, 3'd0, 3'd0, 3'd0, 11'h000, 16'h0800);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    check("mid_rst_busy", {31'h0, busy}, 0);
    check("mid_rst_wr_en", {31'h0, mem_wr_en}, 0);
    check("mid_rst_words", {16'h0, words_written}, 0);
    check("mid_rst_in_ready", {31'h0, in_ready}, 0);
    mem_ack = 1'b1;
    start_session(16'h0600);
    send(5'b01000, 2'd0, 3'd1, 3'd0, 3'd2, 11'h7FD, 16'h415D);
    send(5'b00000, 2'd0, 3'd0, 3'd0, 3'd0, 11'h000, 16'h0000);
    wait_done(16'd2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
